// File: rtl/cp0_exception_controller_if.sv
// Payload types and the CP0 port bundle: writeback mtc0/exception/eret inputs,
// mfc0 read port, and architectural register outputs.
package cp0_exception_controller_pkg;

    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [4:0]        address;
        logic [2:0]        select;
        logic              write_enable;
        logic [DATA_W-1:0] write_data;
    } WBToCP0Data;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       boot_exception_vector;
        logic [5:0] zero_21_16;
        logic [7:0] interrupt_mask;
        logic [5:0] zero_7_2;
        logic       exception_level;
        logic       interrupt_enabled;
    } StatusData;

    typedef struct packed {
        logic        in_delay_slot;
        logic        timer_interrupt;
        logic [13:0] zero_29_16;
        logic [5:0]  hardware_interrupt;
        logic [1:0]  software_interrupt;
        logic        zero_7;
        logic [4:0]  exception_code;
        logic [1:0]  zero_1_0;
    } CauseData;

    typedef logic [DATA_W-1:0] EPCData;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

endpackage

interface cp0_exception_controller_if;
    import cp0_exception_controller_pkg::*;

    WBToCP0Data  wb_to_cp0;
    logic [4:0]  read_register;
    logic [2:0]  read_select;
    logic [31:0] read_data;
    logic        exception_valid;
    logic [4:0]  exception_code;
    logic [31:0] exception_pc;
    logic        exception_in_delay_slot;
    logic [31:0] bad_vaddr;
    logic        eret_valid;
    logic [5:0]  hardware_interrupt;
    logic        interrupt_pending;
    logic        flush;
    logic [31:0] flush_target;
    StatusData   status;
    CauseData    cause;
    EPCData      epc;

    modport master (
        output wb_to_cp0, read_register, read_select, exception_valid, exception_code,
               exception_pc, exception_in_delay_slot, bad_vaddr, eret_valid, hardware_interrupt,
        input  read_data, interrupt_pending, flush, flush_target, status, cause, epc
    );

    modport slave (
        input  wb_to_cp0, read_register, read_select, exception_valid, exception_code,
               exception_pc, exception_in_delay_slot, bad_vaddr, eret_valid, hardware_interrupt,
        output read_data, interrupt_pending, flush, flush_target, status, cause, epc
    );

endinterface

// File: rtl/cp0_exception_controller.sv
// MIPS CP0 subset: Status/Cause/EPC/BadVAddr/Count/Compare, exception and eret
// commit with a one-cycle pipeline flush toward the exception vector or EPC.
module cp0_exception_controller
    import cp0_exception_controller_pkg::*;
#(
    parameter logic [31:0] EXCEPTION_ENTRY = 32'hBFC0_0380
) (
    input  logic                        clock,
    input  logic                        reset_n,
    cp0_exception_controller_if.slave   bus
);

    StatusData   status_q,       status_d;
    CauseData    cause_q,        cause_d;
    EPCData      epc_q,          epc_d;
    logic [31:0] badvaddr_q,     badvaddr_d;
    logic [31:0] count_q,        count_d;
    logic [31:0] compare_q,      compare_d;
    logic        tick_q,         tick_d;
    logic        armed_q,        armed_d;
    logic        flush_q,        flush_d;
    logic [31:0] flush_target_q, flush_target_d;

    logic exc_take, eret_take, wr_sel0;
    logic wr_count, wr_compare, wr_status, wr_cause;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_q       <= '0;
            status_q.boot_exception_vector <= 1'b1;
            cause_q        <= '0;
            epc_q          <= '0;
            badvaddr_q     <= '0;
            count_q        <= '0;
            compare_q      <= '0;
            tick_q         <= 1'b0;
            armed_q        <= 1'b0;
            flush_q        <= 1'b0;
            flush_target_q <= '0;
        end else begin
            status_q       <= status_d;
            cause_q        <= cause_d;
            epc_q          <= epc_d;
            badvaddr_q     <= badvaddr_d;
            count_q        <= count_d;
            compare_q      <= compare_d;
            tick_q         <= tick_d;
            armed_q        <= armed_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
        end
    end

    // Exception beats eret beats mtc0; both commits are dropped while a flush is in flight.
    always_comb begin
        exc_take   = bus.exception_valid && !flush_q;
        eret_take  = bus.eret_valid && !flush_q && !exc_take;
        wr_sel0    = bus.wb_to_cp0.write_enable && !exc_take && !eret_take
                     && (bus.wb_to_cp0.select == 3'd0);
        wr_count   = wr_sel0 && (bus.wb_to_cp0.address == REG_COUNT);
        wr_compare = wr_sel0 && (bus.wb_to_cp0.address == REG_COMPARE);
        wr_status  = wr_sel0 && (bus.wb_to_cp0.address == REG_STATUS);
        wr_cause   = wr_sel0 && (bus.wb_to_cp0.address == REG_CAUSE);

        status_d       = status_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        badvaddr_d     = badvaddr_q;
        count_d        = tick_q ? count_q + 32'd1 : count_q;
        compare_d      = compare_q;
        tick_d         = !tick_q;
        armed_d        = armed_q | wr_compare;
        flush_d        = 1'b0;
        flush_target_d = '0;

        cause_d.hardware_interrupt = {bus.hardware_interrupt[5] | cause_q.timer_interrupt,
                                      bus.hardware_interrupt[4:0]};

        // Compare leaves reset equal to Count, so matching only counts once software programs it.
        if (wr_compare) begin
            cause_d.timer_interrupt = 1'b0;
        end else if (armed_q && (count_q == compare_q)) begin
            cause_d.timer_interrupt = 1'b1;
        end

        if (wr_count)   count_d   = bus.wb_to_cp0.write_data;
        if (wr_compare) compare_d = bus.wb_to_cp0.write_data;
        if (wr_status) begin
            status_d.interrupt_mask    = bus.wb_to_cp0.write_data[15:8];
            status_d.exception_level   = bus.wb_to_cp0.write_data[1];
            status_d.interrupt_enabled = bus.wb_to_cp0.write_data[0];
        end
        if (wr_cause) cause_d.software_interrupt = bus.wb_to_cp0.write_data[9:8];

        if (exc_take) begin
            if (!status_q.exception_level) begin
                epc_d = bus.exception_in_delay_slot ? bus.exception_pc - 32'd4 : bus.exception_pc;
                cause_d.in_delay_slot = bus.exception_in_delay_slot;
            end
            cause_d.exception_code   = bus.exception_code;
            status_d.exception_level = 1'b1;
            if ((bus.exception_code == 5'd4) || (bus.exception_code == 5'd5)) begin
                badvaddr_d = bus.bad_vaddr;
            end
            flush_d        = 1'b1;
            flush_target_d = EXCEPTION_ENTRY;
        end else if (eret_take) begin
            status_d.exception_level = 1'b0;
            flush_d        = 1'b1;
            flush_target_d = epc_q;
        end
    end

    // mfc0 read port, combinational off registered state.
    always_comb begin
        bus.read_data = '0;
        if (bus.read_select == 3'd0) begin
            case (bus.read_register)
                REG_BADVADDR: bus.read_data = badvaddr_q;
                REG_COUNT:    bus.read_data = count_q;
                REG_COMPARE:  bus.read_data = compare_q;
                REG_STATUS:   bus.read_data = status_q;
                REG_CAUSE:    bus.read_data = cause_q;
                REG_EPC:      bus.read_data = epc_q;
                default:      bus.read_data = '0;
            endcase
        end
    end

    assign bus.interrupt_pending = status_q.interrupt_enabled && !status_q.exception_level &&
        (|({cause_q.hardware_interrupt, cause_q.software_interrupt} & status_q.interrupt_mask));
    assign bus.flush        = flush_q;
    assign bus.flush_target = flush_target_q;
    assign bus.status       = status_q;
    assign bus.cause        = cause_q;
    assign bus.epc          = epc_q;

endmodule

// File: tb/tb_cp0_exception_controller.sv
// Directed and randomized checks of cp0_exception_controller against a field-level model.
module tb_cp0_exception_controller;

    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    cp0_exception_controller_if bus ();

    cp0_exception_controller #(.EXCEPTION_ENTRY(32'hBFC0_0380)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Reference state kept as separate architectural fields.
    logic [31:0] m_count, m_compare, m_epc, m_badv, m_target;
    logic        m_tick, m_armed, m_timer, m_ie, m_exl, m_bd, m_flush;
    logic [7:0]  m_im;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    logic [4:0]  m_code;

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | ({24'd0, m_im} << 8) | ({31'd0, m_exl} << 1) | {31'd0, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return ({31'd0, m_bd} << 31) | ({31'd0, m_timer} << 30) | ({26'd0, m_hw} << 10)
             | ({30'd0, m_sw} << 8) | ({27'd0, m_code} << 2);
    endfunction

    function automatic logic m_pending();
        logic [7:0] ip;
        ip = {m_hw, m_sw};
        return m_ie && !m_exl && ((ip & m_im) != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (r)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_target = 0;
        m_tick = 0; m_armed = 0; m_timer = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_flush = 0;
        m_im = 0; m_sw = 0; m_hw = 0; m_code = 0;
    endtask

    task automatic model_step();
        logic        exc, er, wr;
        int          target_reg;
        logic [31:0] wd;
        logic [31:0] n_count;
        logic        n_timer;
        exc = bus.exception_valid && !m_flush;
        er  = bus.eret_valid && !m_flush && !exc;
        wr  = bus.wb_to_cp0.write_enable && !exc && !er && bus.wb_to_cp0.select == 3'd0;
        target_reg = wr ? int'(bus.wb_to_cp0.address) : -1;
        wd = bus.wb_to_cp0.write_data;

        n_count = (target_reg == 9) ? wd : m_count + (m_tick ? 32'd1 : 32'd0);
        n_timer = m_timer;
        if (target_reg == 11) n_timer = 0;
        else if (m_armed && m_count == m_compare) n_timer = 1;
        m_hw = {bus.hardware_interrupt[5] | m_timer, bus.hardware_interrupt[4:0]};
        m_timer = n_timer;
        m_count = n_count;
        m_tick  = !m_tick;
        if (target_reg == 11) begin m_compare = wd; m_armed = 1; end
        if (target_reg == 12) begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
        if (target_reg == 13) m_sw = wd[9:8];

        m_flush = 0; m_target = 0;
        if (exc) begin
            if (!m_exl) begin
                m_epc = bus.exception_pc - (bus.exception_in_delay_slot ? 32'd4 : 32'd0);
                m_bd  = bus.exception_in_delay_slot;
            end
            m_code = bus.exception_code;
            if (m_code == 5'd4 || m_code == 5'd5) m_badv = bus.bad_vaddr;
            m_exl = 1; m_flush = 1; m_target = 32'hBFC0_0380;
        end else if (er) begin
            m_flush = 1; m_target = m_epc; m_exl = 0;
        end
    endtask

    task automatic tick_clk();
        @(posedge clock);
        if (!reset_n) model_reset(); else model_step();
        #1;
    endtask

    task automatic idle();
        bus.wb_to_cp0 = '0;
        bus.exception_valid = 0; bus.exception_code = 0; bus.exception_pc = 0;
        bus.exception_in_delay_slot = 0; bus.bad_vaddr = 0; bus.eret_valid = 0;
        bus.hardware_interrupt = 0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.wb_to_cp0.address = r; bus.wb_to_cp0.select = 0;
        bus.wb_to_cp0.write_enable = 1; bus.wb_to_cp0.write_data = d;
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bv);
        bus.exception_valid = 1; bus.exception_code = code; bus.exception_pc = pc;
        bus.exception_in_delay_slot = ds; bus.bad_vaddr = bv;
    endtask

    task automatic test_reset();
        reset_n = 0; idle(); bus.read_register = 5'd9; bus.read_select = 0;
        model_reset();
        tick_clk(); tick_clk();
        total += 6;
        if (bus.status !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got %h want 00400000", bus.status); end
        if (bus.cause !== 32'h0) begin bad++; $display("FAIL reset_cause got %h want 0", bus.cause); end
        if (bus.epc !== 32'h0) begin bad++; $display("FAIL reset_epc got %h want 0", bus.epc); end
        if (bus.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got %b want 0", bus.flush); end
        if (bus.interrupt_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got %b want 0", bus.interrupt_pending); end
        if (bus.read_data !== 32'h0) begin bad++; $display("FAIL reset_count got %h want 0", bus.read_data); end
        reset_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            total++;
            if (bus.flush !== 1'b0) begin bad++; $display("FAIL boot_flush cycle %0d got %b want 0", i, bus.flush); end
        end
        total += 3;
        if (bus.read_data !== 32'd5) begin bad++; $display("FAIL boot_count got %0d want 5", bus.read_data); end
        if (bus.status !== 32'h0040_0000) begin bad++; $display("FAIL boot_status got %h want 00400000", bus.status); end
        if (bus.cause !== 32'h0) begin bad++; $display("FAIL boot_cause got %h want 0", bus.cause); end
    endtask

    task automatic test_exception();
        raise(5'd4, 32'h8000_0104, 1'b1, 32'h1235); bus.read_register = 5'd8;
        tick_clk(); idle();
        total += 6;
        if (bus.epc !== 32'h8000_0100) begin bad++; $display("FAIL exc_epc got %h want 80000100", bus.epc); end
        if (bus.cause !== 32'h8000_0010) begin bad++; $display("FAIL exc_cause got %h want 80000010", bus.cause); end
        if (bus.status !== 32'h0040_0002) begin bad++; $display("FAIL exc_status got %h want 00400002", bus.status); end
        if (bus.read_data !== 32'h1235) begin bad++; $display("FAIL exc_badvaddr got %h want 1235", bus.read_data); end
        if (bus.flush !== 1'b1) begin bad++; $display("FAIL exc_flush got %b want 1", bus.flush); end
        if (bus.flush_target !== 32'hBFC0_0380) begin bad++; $display("FAIL exc_target got %h want bfc00380", bus.flush_target); end
        tick_clk();
        total += 2;
        if (bus.flush !== 1'b0) begin bad++; $display("FAIL exc_flush_end got %b want 0", bus.flush); end
        if (bus.flush_target !== 32'h0) begin bad++; $display("FAIL exc_target_end got %h want 0", bus.flush_target); end
    endtask

    task automatic test_nested_eret();
        raise(5'd8, 32'h9000_0000, 1'b0, 32'hDEAD); bus.read_register = 5'd8;
        tick_clk(); idle();
        total += 4;
        if (bus.epc !== 32'h8000_0100) begin bad++; $display("FAIL nest_epc got %h want 80000100", bus.epc); end
        if (bus.cause !== 32'h8000_0020) begin bad++; $display("FAIL nest_cause got %h want 80000020", bus.cause); end
        if (bus.read_data !== 32'h1235) begin bad++; $display("FAIL nest_badvaddr got %h want 1235", bus.read_data); end
        if (bus.flush !== 1'b1) begin bad++; $display("FAIL nest_flush got %b want 1", bus.flush); end
        tick_clk();
        bus.eret_valid = 1;
        tick_clk(); idle();
        total += 3;
        if (bus.flush !== 1'b1) begin bad++; $display("FAIL eret_flush got %b want 1", bus.flush); end
        if (bus.flush_target !== 32'h8000_0100) begin bad++; $display("FAIL eret_target got %h want 80000100", bus.flush_target); end
        if (bus.status !== 32'h0040_0000) begin bad++; $display("FAIL eret_status got %h want 00400000", bus.status); end
        tick_clk();
    endtask

    task automatic test_timer();
        logic got = 0;
        bus.read_register = 5'd9;
        mtc0(5'd9, 32'd18);        tick_clk();
        mtc0(5'd11, 32'd20);       tick_clk();
        mtc0(5'd12, 32'h0000_8001); tick_clk(); idle();
        for (int i = 0; i < 20 && !got; i++) begin
            tick_clk();
            if (bus.cause.timer_interrupt === 1'b1) got = 1;
        end
        total += 2;
        if (!got) begin bad++; $display("FAIL timer_set got 0 want 1 within 20 cycles"); end
        if (bus.read_data !== 32'd20) begin bad++; $display("FAIL timer_count got %0d want 20", bus.read_data); end
        tick_clk();
        total++;
        if (bus.interrupt_pending !== 1'b1) begin bad++; $display("FAIL timer_pending got %b want 1", bus.interrupt_pending); end
        mtc0(5'd11, 32'd1000); tick_clk(); idle();
        total++;
        if (bus.cause.timer_interrupt !== 1'b0) begin bad++; $display("FAIL timer_clear got %b want 0", bus.cause.timer_interrupt); end
        tick_clk();
        total++;
        if (bus.interrupt_pending !== 1'b0) begin bad++; $display("FAIL pending_clear got %b want 0", bus.interrupt_pending); end
    endtask

    task automatic test_priority();
        raise(5'd2, 32'h8000_2000, 1'b0, 32'h0); bus.eret_valid = 1; mtc0(5'd12, 32'h0);
        tick_clk(); idle();
        total += 3;
        if (bus.status !== 32'h0040_8003) begin bad++; $display("FAIL prio_status got %h want 00408003", bus.status); end
        if (bus.flush_target !== 32'hBFC0_0380) begin bad++; $display("FAIL prio_target got %h want bfc00380", bus.flush_target); end
        if (bus.epc !== 32'h8000_2000) begin bad++; $display("FAIL prio_epc got %h want 80002000", bus.epc); end
        raise(5'd3, 32'h8000_3000, 1'b0, 32'h0);
        tick_clk(); idle();
        total += 2;
        if (bus.cause.exception_code !== 5'd2) begin bad++; $display("FAIL ignore_code got %0d want 2", bus.cause.exception_code); end
        if (bus.flush !== 1'b0) begin bad++; $display("FAIL ignore_flush got %b want 0", bus.flush); end
        bus.eret_valid = 1; tick_clk(); idle();
        total++;
        if (bus.flush_target !== 32'h8000_2000) begin bad++; $display("FAIL prio_eret got %h want 80002000", bus.flush_target); end
        tick_clk();
    endtask

    task automatic test_count_wrap();
        bus.read_register = 5'd9;
        if (m_tick) tick_clk();
        mtc0(5'd9, 32'hFFFF_FFFF); tick_clk(); idle();
        tick_clk();
        total++;
        if (bus.read_data !== 32'h0) begin bad++; $display("FAIL wrap got %h want 0", bus.read_data); end
        tick_clk();
        mtc0(5'd9, 32'd7); tick_clk(); idle();
        total++;
        if (bus.read_data !== 32'd7) begin bad++; $display("FAIL count_write got %0d want 7", bus.read_data); end
        tick_clk(); tick_clk();
        total++;
        if (bus.read_data !== 32'd8) begin bad++; $display("FAIL count_after got %0d want 8", bus.read_data); end
    endtask

    task automatic test_reset_mid_flush();
        raise(5'd5, 32'h8000_0400, 1'b0, 32'h4444);
        tick_clk(); idle();
        total++;
        if (bus.flush !== 1'b1) begin bad++; $display("FAIL mid_flush_pre got %b want 1", bus.flush); end
        #2 reset_n = 0; model_reset();
        #1;
        total += 2;
        if (bus.flush !== 1'b0) begin bad++; $display("FAIL mid_flush_clear got %b want 0", bus.flush); end
        if (bus.status !== 32'h0040_0000) begin bad++; $display("FAIL mid_reset_status got %h want 00400000", bus.status); end
        tick_clk(); reset_n = 1; bus.read_register = 5'd9;
        tick_clk();
        total++;
        if (bus.read_data !== 32'd0) begin bad++; $display("FAIL post_reset_tick0 got %0d want 0", bus.read_data); end
        tick_clk();
        total++;
        if (bus.read_data !== 32'd1) begin bad++; $display("FAIL post_reset_tick1 got %0d want 1", bus.read_data); end
    endtask

    task automatic test_random();
        logic [4:0] regs [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        for (int i = 0; i < 300; i++) begin
            idle();
            if ($urandom_range(0, 7) == 0)
                raise(5'($urandom_range(0, 12)), {$urandom(), 2'b00} & 32'hFFFF_FFFC, 1'($urandom), $urandom());
            bus.eret_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                mtc0(regs[$urandom_range(0, 6)], $urandom());
                if ($urandom_range(0, 9) == 0) bus.wb_to_cp0.select = 3'd1;
                if (bus.wb_to_cp0.address == 5'd9 && $urandom_range(0, 1) == 1)
                    bus.wb_to_cp0.write_data = m_compare - 32'd2;
            end
            if ($urandom_range(0, 3) == 0) bus.hardware_interrupt = 6'($urandom);
            bus.read_register = 5'($urandom_range(0, 15));
            bus.read_select   = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0;
            tick_clk();
            total += 7;
            if (bus.status !== m_status()) begin bad++; $display("FAIL rnd_status %0d got %h want %h", i, bus.status, m_status()); end
            if (bus.cause !== m_cause()) begin bad++; $display("FAIL rnd_cause %0d got %h want %h", i, bus.cause, m_cause()); end
            if (bus.epc !== m_epc) begin bad++; $display("FAIL rnd_epc %0d got %h want %h", i, bus.epc, m_epc); end
            if (bus.flush !== m_flush) begin bad++; $display("FAIL rnd_flush %0d got %b want %b", i, bus.flush, m_flush); end
            if (bus.flush_target !== m_target) begin bad++; $display("FAIL rnd_target %0d got %h want %h", i, bus.flush_target, m_target); end
            if (bus.read_data !== m_read(bus.read_register, bus.read_select)) begin
                bad++; $display("FAIL rnd_read %0d got %h want %h", i, bus.read_data, m_read(bus.read_register, bus.read_select));
            end
            if (bus.interrupt_pending !== m_pending()) begin bad++; $display("FAIL rnd_pending %0d got %b want %b", i, bus.interrupt_pending, m_pending()); end
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_nested_eret();
        test_timer();
        test_priority();
        test_count_wrap();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
